// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: state codes, default timing
// constants, result codes and small helpers. The testbench imports this
// package for its db_estado checks.
package jogador_automatico_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PULSA_JOGAR = 4'd1,
    CAPTURA     = 4'd2,
    ESPERA      = 4'd3,
    PRESSIONA   = 4'd4,
    SOLTA       = 4'd5,
    PROX_RODADA = 4'd6,
    FIM         = 4'd7
  } estado_t;

  localparam int HOLD_CYC_DEF    = 10;
  localparam int GAP_CYC_DEF     = 10;
  localparam int JOGAR_CYC_DEF   = 5;
  localparam int TIMEOUT_CAP_DEF = 4000;

  localparam logic [1:0] RES_NENHUM = 2'b00;
  localparam logic [1:0] RES_GANHOU = 2'b01;
  localparam logic [1:0] RES_PERDEU = 2'b10;

  localparam logic [3:0] ULTIMA_RODADA = 4'd15;

  // True for exactly one bit set.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Rotate left by one: the deliberately wrong button for error injection.
  function automatic logic [3:0] rot_left(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic int max_of(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Player <-> game connection. The player (master) drives jogar/botoes and
// observes the game display and result strobes; the game is the slave.
interface jogador_automatico_if;
  logic       jogar;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       ganhou;
  logic       perdeu;
  logic       pronto;

  modport master (output jogar, botoes, input leds, ganhou, perdeu, pronto);
  modport slave  (input jogar, botoes, output leds, ganhou, perdeu, pronto);
endinterface

// File: rtl/jogador_automatico_memoria_jogadas.sv
// 16x4 storage for the captured sequence: synchronous write, asynchronous read.
module memoria_jogadas (
  input  logic       clock,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [3:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [3:0] rdata_o
);

  logic [3:0] mem_q [16];

  // Write port. NOTE: storage has no reset; every entry read in a round is
  // written by the capture phase first, so clearing it would only cost logic.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: watches the game's led sequence, stores it, then replays
// it on botoes with fixed press/release timing, one round longer each time.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int JOGAR_CYC   = JOGAR_CYC_DEF,
  parameter int TIMEOUT_CAP = TIMEOUT_CAP_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  injetar_erro,
  input  logic [3:0]            erro_rodada,
  jogador_automatico_if.master  jogo,
  output logic                  ocupado,
  output logic [3:0]            db_estado,
  output logic [3:0]            db_rodada,
  output logic [1:0]            db_resultado
);

  localparam int MAX_CYC = max_of(HOLD_CYC, GAP_CYC, JOGAR_CYC, TIMEOUT_CAP);
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] HOLD_FIM    = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_FIM     = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] JOGAR_FIM   = TMR_W'(JOGAR_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_FIM = TMR_W'(TIMEOUT_CAP - 1);

  estado_t          estado_q;
  logic [TMR_W-1:0] tmr_q;
  logic [3:0]       rodada_q;
  logic [3:0]       k_q;
  logic [3:0]       leds_prev_q;
  logic [3:0]       botoes_q;
  logic             jogar_q;
  logic             ocupado_q;
  logic [1:0]       resultado_q;

  logic       abortar;
  logic       captura;
  logic       mem_we;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic       injeta;
  logic [3:0] valor_press;

  // Abort/capture detection and selection of the next button value.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    abortar     = 1'b0;
    captura     = 1'b0;
    rd_addr     = k_q;
    injeta      = 1'b0;
    valor_press = 4'd0;

    if (estado_q != INICIAL && estado_q != FIM)
      abortar = jogo.ganhou | jogo.perdeu | jogo.pronto;

    // A step is a 0000 -> one-hot edge; other nonzero patterns are glitches.
    captura = (estado_q == CAPTURA) && (leds_prev_q == 4'd0) && is_one_hot(jogo.leds);

    // Leaving SOLTA loads the following press, so look one entry ahead.
    if (estado_q == SOLTA) rd_addr = k_q + 4'd1;

    injeta      = injetar_erro && (rodada_q == erro_rodada) && (rd_addr == rodada_q);
    valor_press = injeta ? rot_left(rd_data) : rd_data;
  end

  assign mem_we = captura && !abortar && !reset;

  memoria_jogadas u_mem (
    .clock   (clock),
    .we_i    (mem_we),
    .waddr_i (k_q),
    .wdata_i (jogo.leds),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Player FSM with all outputs registered alongside the state.
  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge values of the other registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= INICIAL;
      tmr_q       <= '0;
      rodada_q    <= 4'd0;
      k_q         <= 4'd0;
      leds_prev_q <= 4'd0;
      botoes_q    <= 4'd0;
      jogar_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      resultado_q <= RES_NENHUM;
    end else begin
      leds_prev_q <= jogo.leds;
      if (abortar) begin
        estado_q  <= FIM;
        tmr_q     <= '0;
        botoes_q  <= 4'd0;
        jogar_q   <= 1'b0;
        ocupado_q <= 1'b0;
        if (jogo.ganhou)      resultado_q <= RES_GANHOU;
        else if (jogo.perdeu) resultado_q <= RES_PERDEU;
      end else begin
        unique case (estado_q)
          INICIAL, FIM: begin
            if (iniciar) begin
              estado_q    <= PULSA_JOGAR;
              tmr_q       <= '0;
              rodada_q    <= 4'd0;
              k_q         <= 4'd0;
              jogar_q     <= 1'b1;
              ocupado_q   <= 1'b1;
              resultado_q <= RES_NENHUM;
            end
          end
          PULSA_JOGAR: begin
            if (tmr_q == JOGAR_FIM) begin
              estado_q <= CAPTURA;
              tmr_q    <= '0;
              jogar_q  <= 1'b0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          CAPTURA: begin
            if (captura) begin
              tmr_q <= '0;
              if (k_q == rodada_q) begin
                estado_q <= ESPERA;
                k_q      <= 4'd0;
              end else begin
                k_q <= k_q + 4'd1;
              end
            end else if (tmr_q == TIMEOUT_FIM) begin
              estado_q <= ESPERA;
              tmr_q    <= '0;
              k_q      <= 4'd0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          ESPERA: begin
            if (tmr_q == GAP_FIM) begin
              estado_q <= PRESSIONA;
              tmr_q    <= '0;
              botoes_q <= valor_press;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          PRESSIONA: begin
            if (tmr_q == HOLD_FIM) begin
              estado_q <= SOLTA;
              tmr_q    <= '0;
              botoes_q <= 4'd0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          SOLTA: begin
            if (tmr_q == GAP_FIM) begin
              tmr_q <= '0;
              if (k_q < rodada_q) begin
                estado_q <= PRESSIONA;
                k_q      <= k_q + 4'd1;
                botoes_q <= valor_press;
              end else begin
                estado_q <= PROX_RODADA;
              end
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          PROX_RODADA: begin
            tmr_q <= '0;
            k_q   <= 4'd0;
            if (rodada_q == ULTIMA_RODADA) begin
              estado_q  <= FIM;
              ocupado_q <= 1'b0;
            end else begin
              estado_q <= CAPTURA;
              rodada_q <= rodada_q + 4'd1;
            end
          end
          default: begin
            estado_q  <= INICIAL;
            ocupado_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign jogo.jogar   = jogar_q;
  assign jogo.botoes  = botoes_q;
  assign ocupado      = ocupado_q;
  assign db_estado    = estado_q;
  assign db_rodada    = rodada_q;
  assign db_resultado = resultado_q;

endmodule
